sram_fetch_engine: RTL and testbench

- Data mover under control of sram_controller.
- Starts on a start_sram pulse and reads a contiguous block from external SRAM: image pixels when n_coef_image=1, one coefficient set when n_coef_image=0.
- Writes each returned word to the destination buffer with an index, then pulses sram_done back to the controller.
- Tracks which coefficient set comes next, so repeated coefficient loads walk through successive sets.

---
 rtl/sram_fetch_engine.sv | 151 +++++++++++++++
 tb/tb_sram_fetch_engine.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fetch_engine.sv
// Block fetch engine: streams a contiguous SRAM region (image or one coefficient set) into a destination buffer.
// Optional running checksum output enabled by defining SRAM_FETCH_CKSUM_EN.
module sram_fetch_engine #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int IMG_BASE      = 0,
    parameter int IMG_WORDS     = 784,
    parameter int COEF_BASE     = 1024,
    parameter int COEF_WORDS    = 64,
    parameter int NUM_COEF_SETS = 2,
    parameter int READ_LATENCY  = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start_sram,
    input  logic              n_coef_image,
    input  logic              mem_busy,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_idx,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              sram_done
`ifdef SRAM_FETCH_CKSUM_EN
    ,
    output logic [DATA_W-1:0] cksum
`endif
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int SET_W = (NUM_COEF_SETS > 1) ? $clog2(NUM_COEF_SETS) : 1;

    // Handshake: mem_re is a request that is only asserted when mem_busy is low,
    // so every cycle with mem_re=1 is an accepted read; no read is ever retried.
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_next;

    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  ret_cnt;
    logic              mode;
    logic [SET_W-1:0]  coef_set;
    logic [READ_LATENCY-1:0] vld;
    logic              start_ok;
    logic [ADDR_W-1:0] coef_base;

    assign start_ok  = (state == IDLE) && start_sram;
    assign coef_base = ADDR_W'(COEF_BASE) + ADDR_W'(coef_set) * ADDR_W'(COEF_WORDS);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_re     = 1'b0;
        busy       = 1'b0;
        sram_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start_sram) state_next = ISSUE;
            end
            ISSUE: begin
                busy   = 1'b1;
                mem_re = !mem_busy;
                if (!mem_busy && (issue_cnt == len - CNT_W'(1))) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (ret_cnt == len) state_next = DONE;
            end
            DONE: begin
                sram_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Valid pipeline mirrors the SRAM read latency; its last stage marks mem_rdata valid.
    generate
        if (READ_LATENCY == 1) begin : g_vld1
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) vld <= '0;
                else        vld <= mem_re;
            end
        end else begin : g_vldn
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) vld <= '0;
                else        vld <= {vld[READ_LATENCY-2:0], mem_re};
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            len       <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            mode      <= 1'b0;
            coef_set  <= '0;
            mem_addr  <= '0;
            wr_en     <= 1'b0;
            wr_sel    <= 1'b0;
            wr_idx    <= '0;
            wr_data   <= '0;
        end else begin
            wr_en <= vld[READ_LATENCY-1];
            if (vld[READ_LATENCY-1]) begin
                wr_data <= mem_rdata;
                wr_idx  <= ret_cnt[ADDR_W-1:0];
                wr_sel  <= mode;
                ret_cnt <= ret_cnt + CNT_W'(1);
            end
            if (mem_re) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
                mem_addr  <= mem_addr + ADDR_W'(1);
            end
            if (state == DONE && !mode) begin
                if (coef_set == SET_W'(NUM_COEF_SETS - 1)) coef_set <= '0;
                else                                       coef_set <= coef_set + SET_W'(1);
            end
            if (start_ok) begin
                mode      <= n_coef_image;
                issue_cnt <= '0;
                ret_cnt   <= '0;
                if (n_coef_image) begin
                    len      <= CNT_W'(IMG_WORDS);
                    mem_addr <= ADDR_W'(IMG_BASE);
                    coef_set <= '0;
                end else begin
                    len      <= CNT_W'(COEF_WORDS);
                    mem_addr <= coef_base;
                end
            end
        end
    end

`ifdef SRAM_FETCH_CKSUM_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)      cksum <= '0;
        else if (start_ok) cksum <= '0;
        else if (wr_en)  cksum <= cksum + wr_data;
    end
`endif

endmodule

// File: tb/tb_sram_fetch_engine.sv
// Directed bench for sram_fetch_engine: image/coef loads, set walking, stalls, ignored start, reset abort.
module tb_sram_fetch_engine;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start_sram = 1'b0;
    logic          n_coef_image = 1'b0;
    logic          mem_busy = 1'b0;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_idx;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          sram_done;
`ifdef SRAM_FETCH_CKSUM_EN
    logic [DW-1:0] cksum;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [AW-1:0] re_addr_q[$];
    int            re_cyc_q[$];
    logic [AW-1:0] wr_idx_q[$];
    logic [DW-1:0] wr_data_q[$];
    logic          wr_sel_q[$];
    int            wr_cyc_q[$];
    int            done_cyc_q[$];

    sram_fetch_engine #(
        .ADDR_W(AW), .DATA_W(DW), .IMG_BASE(0), .IMG_WORDS(8),
        .COEF_BASE(16'h0100), .COEF_WORDS(4), .NUM_COEF_SETS(2), .READ_LATENCY(2)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start_sram(start_sram), .n_coef_image(n_coef_image),
        .mem_busy(mem_busy), .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
        .busy(busy), .sram_done(sram_done)
`ifdef SRAM_FETCH_CKSUM_EN
        , .cksum(cksum)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: rdata equals the address issued two cycles earlier
    logic [AW-1:0] sram_a1 = '0;
    logic [DW-1:0] sram_rd = '0;
    always @(posedge clk) begin
        sram_a1 <= mem_re ? mem_addr : 16'hDEAD;
        sram_rd <= sram_a1;
    end
    assign mem_rdata = sram_rd;

    // event log sampled mid-cycle
    always @(negedge clk) begin
        if (mem_re) begin
            re_addr_q.push_back(mem_addr);
            re_cyc_q.push_back(cyc);
        end
        if (wr_en) begin
            wr_idx_q.push_back(wr_idx);
            wr_data_q.push_back(wr_data);
            wr_sel_q.push_back(wr_sel);
            wr_cyc_q.push_back(cyc);
        end
        if (sram_done) done_cyc_q.push_back(cyc);
    end

    // driver tasks
    task automatic clear_logs();
        re_addr_q.delete(); re_cyc_q.delete();
        wr_idx_q.delete(); wr_data_q.delete(); wr_sel_q.delete(); wr_cyc_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic start_load(input logic img);
        @(posedge clk); #1;
        n_coef_image = img;
        start_sram   = 1'b1;
        @(posedge clk); #1;
        start_sram   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sram_done) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_reads(input int n, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (re_addr_q.size() >= n) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // tests
    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({mem_re, mem_addr, wr_en, wr_sel, wr_idx, wr_data, busy, sram_done} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got re=%b addr=%h wr_en=%b sel=%b idx=%h data=%h busy=%b done=%b, expected all 0",
                     mem_re, mem_addr, wr_en, wr_sel, wr_idx, wr_data, busy, sram_done);
        end
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_image();
        bit to;
        clear_logs();
        start_load(1'b1);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL img_busy: got %b expected 1", busy); end
        wait_done(100, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL img_timeout: no sram_done within 100 cycles"); end
        n_checks++;
        if (re_addr_q.size() != 8) begin n_errors++; $display("FAIL img_reads: got %0d expected 8", re_addr_q.size()); end
        for (int i = 0; i < re_addr_q.size() && i < 8; i++) begin
            n_checks++;
            if (re_addr_q[i] !== 16'(i) || re_cyc_q[i] != re_cyc_q[0] + i) begin
                n_errors++;
                $display("FAIL img_read%0d: got addr=%h cyc+%0d expected addr=%h cyc+%0d",
                         i, re_addr_q[i], re_cyc_q[i] - re_cyc_q[0], 16'(i), i);
            end
        end
        n_checks++;
        if (wr_idx_q.size() != 8) begin n_errors++; $display("FAIL img_writes: got %0d expected 8", wr_idx_q.size()); end
        for (int i = 0; i < wr_idx_q.size() && i < 8; i++) begin
            n_checks++;
            if (wr_sel_q[i] !== 1'b1 || wr_idx_q[i] !== 16'(i) || wr_data_q[i] !== 16'(i)) begin
                n_errors++;
                $display("FAIL img_write%0d: got sel=%b idx=%h data=%h expected sel=1 idx=%h data=%h",
                         i, wr_sel_q[i], wr_idx_q[i], wr_data_q[i], 16'(i), 16'(i));
            end
        end
        if (wr_cyc_q.size() == 8 && re_cyc_q.size() == 8) begin
            n_checks++;
            if (wr_cyc_q[0] - re_cyc_q[0] != 3) begin
                n_errors++;
                $display("FAIL img_latency: got %0d expected 3", wr_cyc_q[0] - re_cyc_q[0]);
            end
        end
        n_checks++;
        if (done_cyc_q.size() != 1) begin
            n_errors++; $display("FAIL img_done_count: got %0d expected 1", done_cyc_q.size());
        end else if (wr_cyc_q.size() == 8) begin
            n_checks++;
            if (done_cyc_q[0] != wr_cyc_q[7] + 1) begin
                n_errors++;
                $display("FAIL img_done_timing: got done-lastwr=%0d expected 1", done_cyc_q[0] - wr_cyc_q[7]);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL img_busy_after: got %b expected 0", busy); end
`ifdef SRAM_FETCH_CKSUM_EN
        n_checks++;
        if (cksum !== 16'h001C) begin n_errors++; $display("FAIL img_cksum: got %h expected 001c", cksum); end
`endif
    endtask

    task automatic test_coef_sets();
        bit to;
        logic [AW-1:0] bases [3];
        bases[0] = 16'h0100; bases[1] = 16'h0104; bases[2] = 16'h0100;
        for (int l = 0; l < 3; l++) begin
            clear_logs();
            start_load(1'b0);
            wait_done(100, to);
            n_checks++;
            if (to) begin n_errors++; $display("FAIL coef%0d_timeout: no sram_done", l); end
            n_checks++;
            if (re_addr_q.size() != 4 || wr_idx_q.size() != 4 || done_cyc_q.size() != 1) begin
                n_errors++;
                $display("FAIL coef%0d_counts: got reads=%0d writes=%0d done=%0d expected 4/4/1",
                         l, re_addr_q.size(), wr_idx_q.size(), done_cyc_q.size());
            end
            for (int i = 0; i < re_addr_q.size() && i < 4; i++) begin
                n_checks++;
                if (re_addr_q[i] !== bases[l] + 16'(i)) begin
                    n_errors++;
                    $display("FAIL coef%0d_addr%0d: got %h expected %h", l, i, re_addr_q[i], bases[l] + 16'(i));
                end
            end
            for (int i = 0; i < wr_idx_q.size() && i < 4; i++) begin
                n_checks++;
                if (wr_sel_q[i] !== 1'b0 || wr_idx_q[i] !== 16'(i) || wr_data_q[i] !== bases[l] + 16'(i)) begin
                    n_errors++;
                    $display("FAIL coef%0d_write%0d: got sel=%b idx=%h data=%h expected sel=0 idx=%h data=%h",
                             l, i, wr_sel_q[i], wr_idx_q[i], wr_data_q[i], 16'(i), bases[l] + 16'(i));
                end
            end
`ifdef SRAM_FETCH_CKSUM_EN
            n_checks++;
            if (cksum !== bases[l] * 16'd4 + 16'd6) begin
                n_errors++; $display("FAIL coef%0d_cksum: got %h expected %h", l, cksum, bases[l] * 16'd4 + 16'd6);
            end
`endif
        end
    endtask

    task automatic test_busy_stall();
        bit to;
        clear_logs();
        start_load(1'b1);
        wait_reads(3, 50, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL stall_wait: fewer than 3 reads issued"); end
        mem_busy = 1'b1;
        #1;
        n_checks++;
        if (mem_re !== 1'b0) begin n_errors++; $display("FAIL stall_re: got %b expected 0", mem_re); end
        repeat (3) @(posedge clk);
        #1;
        mem_busy = 1'b0;
        wait_done(100, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL stall_timeout: no sram_done"); end
        n_checks++;
        if (re_addr_q.size() != 8 || wr_idx_q.size() != 8 || done_cyc_q.size() != 1) begin
            n_errors++;
            $display("FAIL stall_counts: got reads=%0d writes=%0d done=%0d expected 8/8/1",
                     re_addr_q.size(), wr_idx_q.size(), done_cyc_q.size());
        end else begin
            n_checks++;
            if (re_cyc_q[7] - re_cyc_q[0] != 10) begin
                n_errors++; $display("FAIL stall_span: got %0d expected 10", re_cyc_q[7] - re_cyc_q[0]);
            end
        end
        for (int i = 0; i < re_addr_q.size() && i < 8; i++) begin
            n_checks++;
            if (re_addr_q[i] !== 16'(i)) begin
                n_errors++; $display("FAIL stall_addr%0d: got %h expected %h", i, re_addr_q[i], 16'(i));
            end
        end
        for (int i = 0; i < wr_idx_q.size() && i < 8; i++) begin
            n_checks++;
            if (wr_idx_q[i] !== 16'(i) || wr_data_q[i] !== 16'(i) || wr_sel_q[i] !== 1'b1) begin
                n_errors++;
                $display("FAIL stall_write%0d: got sel=%b idx=%h data=%h expected sel=1 idx=%h data=%h",
                         i, wr_sel_q[i], wr_idx_q[i], wr_data_q[i], 16'(i), 16'(i));
            end
        end
`ifdef SRAM_FETCH_CKSUM_EN
        n_checks++;
        if (cksum !== 16'h001C) begin n_errors++; $display("FAIL stall_cksum: got %h expected 001c", cksum); end
`endif
    endtask

    task automatic test_ignore_start();
        bit to;
        clear_logs();
        start_load(1'b0);
        wait_reads(1, 50, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL ign_wait: no read issued"); end
        n_coef_image = 1'b1;
        start_sram   = 1'b1;
        @(posedge clk); #1;
        start_sram   = 1'b0;
        wait_done(100, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL ign_timeout: no sram_done"); end
        n_checks++;
        if (wr_idx_q.size() != 4 || done_cyc_q.size() != 1 || re_addr_q.size() != 4) begin
            n_errors++;
            $display("FAIL ign_counts: got reads=%0d writes=%0d done=%0d expected 4/4/1",
                     re_addr_q.size(), wr_idx_q.size(), done_cyc_q.size());
        end
        for (int i = 0; i < wr_idx_q.size() && i < 4; i++) begin
            n_checks++;
            if (wr_sel_q[i] !== 1'b0 || wr_idx_q[i] !== 16'(i) || wr_data_q[i] !== 16'h0100 + 16'(i)) begin
                n_errors++;
                $display("FAIL ign_write%0d: got sel=%b idx=%h data=%h expected sel=0 idx=%h data=%h",
                         i, wr_sel_q[i], wr_idx_q[i], wr_data_q[i], 16'(i), 16'h0100 + 16'(i));
            end
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (done_cyc_q.size() != 1 || busy !== 1'b0) begin
            n_errors++; $display("FAIL ign_no_restart: got done=%0d busy=%b expected 1 and 0", done_cyc_q.size(), busy);
        end
    endtask

    task automatic test_reset_abort();
        bit to;
        clear_logs();
        start_load(1'b1);
        wait_reads(1, 50, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL abort_wait: no read issued"); end
        @(posedge clk); #1;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if ({mem_re, mem_addr, wr_en, wr_sel, wr_idx, wr_data, busy, sram_done} !== '0) begin
            n_errors++;
            $display("FAIL abort_outputs: got re=%b addr=%h wr_en=%b sel=%b idx=%h data=%h busy=%b done=%b, expected all 0",
                     mem_re, mem_addr, wr_en, wr_sel, wr_idx, wr_data, busy, sram_done);
        end
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (wr_idx_q.size() != 0 || done_cyc_q.size() != 0 || re_addr_q.size() != 0) begin
            n_errors++;
            $display("FAIL abort_quiet: got reads=%0d writes=%0d done=%0d expected 0/0/0",
                     re_addr_q.size(), wr_idx_q.size(), done_cyc_q.size());
        end
        clear_logs();
        start_load(1'b0);
        wait_done(100, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL abort_coef_timeout: no sram_done"); end
        n_checks++;
        if (re_addr_q.size() != 4 || wr_data_q.size() != 4) begin
            n_errors++;
            $display("FAIL abort_coef_counts: got reads=%0d writes=%0d expected 4/4", re_addr_q.size(), wr_data_q.size());
        end else begin
            n_checks++;
            if (re_addr_q[0] !== 16'h0100 || wr_data_q[3] !== 16'h0103) begin
                n_errors++;
                $display("FAIL abort_coef_set0: got addr0=%h data3=%h expected 0100 and 0103", re_addr_q[0], wr_data_q[3]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_image();
        test_coef_sets();
        test_busy_stall();
        test_ignore_start();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
